// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding, default operand width and the iteration-counter width helper.
package seq_restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold WIDTH-1; keep at least one bit so WIDTH=1 still builds.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ripple_borrow_subtractor.sv
// N-bit ripple-borrow subtractor built from full-subtractor cells.
// difference = minuend_i - subtrahend_i (mod 2^N); borrow_out is set when
// the subtrahend is larger than the minuend.
module ripple_borrow_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] minuend_i,
  input  logic [N-1:0] subtrahend_i,
  output logic [N-1:0] difference,
  output logic         borrow_out
);

  logic [N:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign difference[i] = minuend_i[i] ^ subtrahend_i[i] ^ borrow[i];
    assign borrow[i+1]   = (~minuend_i[i] & subtrahend_i[i]) |
                           (~(minuend_i[i] ^ subtrahend_i[i]) & borrow[i]);
  end

  assign borrow_out = borrow[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB
// first. A zero divisor short-cuts to DONE with Q=all-ones, R=A and the
// div_by_zero flag. Results are registered and held until the next division
// completes.
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on acceptance
//   CALC  | one restoring step per cycle, WIDTH cycles
//   DONE  | done pulse for one cycle, then back to IDLE
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             keep_diff;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // Partial remainder shifted left with the next dividend bit appended.
  assign shifted = {rem_q, a_q[WIDTH-1]};

  ripple_borrow_subtractor #(
    .N(WIDTH + 1)
  ) u_trial_sub (
    .minuend_i    (shifted),
    .subtrahend_i ({1'b0, b_q}),
    .difference   (diff),
    .borrow_out   (borrow)
  );

  // Restoring decision: keep the difference only when it is non-negative and
  // fits the remainder width (the latter always holds when there is no borrow).
  always_comb begin
    keep_diff = ~borrow & ~diff[WIDTH];
    rem_d     = keep_diff ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_d     = (quo_q << 1) | WIDTH'(keep_diff);
  end

  // Control FSM with iteration counter and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= CW'(WIDTH - 1);
            if (B == '0) begin
              state_q <= DONE;
              q_q     <= '1;
              r_q     <= A;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          a_q   <= a_q << 1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            q_q     <= quo_d;
            r_q     <= rem_d;
            dbz_q   <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4): directed vector
// table, multi-cycle corner sequences and an exhaustive operand sweep, with a
// scoreboard queue popped on every done pulse.
module tb_seq_restoring_divider;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int passed = 0;
  int total = 0;
  int done_cnt = 0;
  exp_t sb[$];

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;
  logic         prev_dbz;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("Q", 32'(Q), 32'(e.q));
        check("R", 32'(R), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dbz = dbz;
    sb.push_back(e);
  endtask

  task automatic set_prev(input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
    prev_q = q;
    prev_r = r;
    prev_dbz = dbz;
  endtask

  // One division from IDLE; entered and left #1 after a rising edge.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    int n;
    int bad_busy;
    int bad_hold;
    A = a;
    B = b;
    start = 1'b1;
    push_exp(eq, er, edbz);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    bad_busy = 0;
    bad_hold = 0;
    while (done !== 1'b1 && n < 3 * W) begin
      if (busy !== 1'b1) bad_busy++;
      if (Q !== prev_q || R !== prev_r || div_by_zero !== prev_dbz) bad_hold++;
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), (b == '0) ? 32'd0 : 32'(W));
    check("busy_during_calc", 32'(bad_busy), 32'd0);
    check("outputs_held_in_calc", 32'(bad_hold), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
    set_prev(eq, er, edbz);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  // Main stimulus.
  initial begin
    vec_t vecs[9];
    int n;
    int dc0;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ed;

    vecs[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, dbz: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dbz: 1'b0};
    vecs[2] = '{a: 4'd3,  b: 4'd7,  q: 4'd0,  r: 4'd3, dbz: 1'b0};
    vecs[3] = '{a: 4'd9,  b: 4'd0,  q: 4'hF,  r: 4'd9, dbz: 1'b1};
    vecs[4] = '{a: 4'd14, b: 4'd3,  q: 4'd4,  r: 4'd2, dbz: 1'b0};
    vecs[5] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dbz: 1'b0};
    vecs[6] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dbz: 1'b0};
    vecs[7] = '{a: 4'd7,  b: 4'd2,  q: 4'd3,  r: 4'd1, dbz: 1'b0};
    vecs[8] = '{a: 4'd0,  b: 4'd0,  q: 4'hF,  r: 4'd0, dbz: 1'b1};

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    set_prev('0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_Q", 32'(Q), 32'd0);
    check("reset_R", 32'(R), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
    end

    // Back-to-back with start held high through done.
    A = 4'd15;
    B = 4'd1;
    start = 1'b1;
    push_exp(4'd15, 4'd0, 1'b0);
    @(posedge clk); #1;
    A = 4'd3;
    B = 4'd7;
    push_exp(4'd0, 4'd3, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 3 * W) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_latency", 32'(n), 32'(W));
    @(posedge clk); #1;
    n = 1;
    while (done !== 1'b1 && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_second_gap", 32'(n), 32'(W + 2));
    start = 1'b0;
    set_prev(4'd0, 4'd3, 1'b0);
    @(posedge clk); #1;

    // New operands and start during CALC cycle 2 are ignored.
    dc0 = done_cnt;
    A = 4'd14;
    B = 4'd3;
    start = 1'b1;
    push_exp(4'd4, 4'd2, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    A = 4'd1;
    B = 4'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 2;
    while (done !== 1'b1 && n < 3 * W) begin
      @(posedge clk); #1;
      n++;
    end
    check("ignore_start_latency", 32'(n), 32'(W));
    repeat (10) @(posedge clk);
    #1;
    check("ignore_start_single_done", 32'(done_cnt - dc0), 32'd1);
    set_prev(4'd4, 4'd2, 1'b0);

    // Reset during CALC cycle 2 aborts without a done pulse.
    dc0 = done_cnt;
    A = 4'd10;
    B = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_Q", 32'(Q), 32'd0);
    check("abort_R", 32'(R), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    set_prev('0, '0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    do_div(4'd10, 4'd3, 4'd3, 4'd1, 1'b0);

    // Exhaustive sweep against the arithmetic reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 4'hF;
          er = 4'(a);
          ed = 1'b1;
        end else begin
          eq = 4'(a / b);
          er = 4'(a % b);
          ed = 1'b0;
        end
        do_div(4'(a), 4'(b), eq, er, ed);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
SEQ_RESTORING_DIVIDER -- requirements
Module: seq_restoring_divider

Interface
REQ-001 The block SHALL have the parameter: WIDTH, default 4, operand/result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port A, input, WIDTH bits: unsigned dividend.
REQ-006 The block SHALL have port B, input, WIDTH bits: unsigned divisor.
REQ-007 The block SHALL have port Q, output, WIDTH bits: quotient.
REQ-008 The block SHALL have port R, output, WIDTH bits: remainder.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking Q/R valid.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: high with done when B was 0.

Function
REQ-012 The block SHALL implement three states: IDLE, CALC, DONE.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL latch A and B into internal registers, clear the partial remainder, load the iteration counter with WIDTH-1, and go to CALC; busy=1 from the next cycle.
REQ-014 If the latched B is 0, the block SHALL go directly from IDLE to DONE instead, setting Q=all-ones, R=A and div_by_zero=1.
REQ-015 Each CALC cycle SHALL perform one restoring step, MSB first:
- Shift the WIDTH+1-bit partial remainder left, inserting the current dividend bit.
- Subtract B zero-extended to WIDTH+1 bits.
- If there is no borrow, keep the difference and set the quotient bit to 1.
- Otherwise keep the shifted value and set the quotient bit to 0.
REQ-016 CALC SHALL last exactly WIDTH cycles. After the step for bit 0, the block SHALL go to DONE.
REQ-017 In DONE, the block SHALL assert done=1 for exactly one cycle with busy=0, then return to IDLE.
REQ-018 Latency: for a nonzero divisor, done SHALL be high in the cycle that begins WIDTH+1 rising edges after the accepting edge (5 for WIDTH=4). For a zero divisor, 1 edge.
REQ-019 Q, R and div_by_zero SHALL hold their values from DONE until the next accepted start. They SHALL not change during CALC; intermediate values stay internal.
REQ-020 start SHALL be ignored while in CALC or DONE. A and B changes after acceptance SHALL have no effect.
REQ-021 start asserted in the same cycle done is high SHALL be ignored. It is accepted at the first edge in IDLE.
REQ-022 Results SHALL satisfy A = Q*B + R with R < B for all nonzero B.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE and clear Q, R, busy, done, div_by_zero, the counter and all internal registers to 0.
REQ-024 rst SHALL take priority over start and over any in-progress operation. A reset mid-CALC SHALL abort with no done pulse.
REQ-025 The first edge with rst=0 and start=1 SHALL accept a new division normally.

Structure
REQ-026 The state encoding constants (IDLE, CALC, DONE) SHALL live in a shared package, together with the default WIDTH.
REQ-027 The trial subtraction SHALL be a separate sub-module, ripple_borrow_subtractor: WIDTH+1 bits, built from full-subtractor cells chained by borrow, with outputs difference and borrow_out. The FSM, counter and registers SHALL stay in seq_restoring_divider.

Verification
REQ-028 A=13, B=4, start pulsed once: the bench SHALL see Q=3, R=1, done high exactly 5 cycles after the accepting edge, busy=1 for the 4 preceding cycles.
REQ-029 A=15, B=1: the bench SHALL see Q=15, R=0. Then A=3, B=7 back-to-back, start held high through done: the bench SHALL see the second accepted only in IDLE, Q=0, R=3.
REQ-030 A=9, B=0: the bench SHALL see done after 1 edge, div_by_zero=1, Q=4'hF, R=9, busy never high.
REQ-031 A=14, B=3 accepted, with A=1, B=1 and start=1 driven during cycle 2 of CALC: the bench SHALL see Q=4, R=2 and only one done.
REQ-032 A=10, B=3 accepted, rst=1 in cycle 2 of CALC: the bench SHALL see all outputs 0 next cycle and no done; a following A=10, B=3 SHALL yield Q=3, R=1.
REQ-033 Exhaustive WIDTH=4 sweep of all 256 A/B pairs: the bench SHALL check every result against REQ-022 and REQ-014.
